// File: rtl/alu_link_defs_pkg.sv
// alu_link_defs: state encodings, frame sizes and timeout default shared by both ends of the ALU serial link
package alu_link_defs;
   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LOAD    = 3'd1;
   localparam logic [2:0] ST_WAIT_TX = 3'd2;
   localparam logic [2:0] ST_RECV    = 3'd3;
   localparam logic [2:0] ST_RESP    = 3'd4;
   localparam logic [3:0] REQ_BYTES = 4'd9;
   localparam logic [3:0] RES_BYTES = 4'd4;
   localparam logic [19:0] TIMEOUT_DEFAULT = 20'd1000000;
   // Request frame is packed {op, b, a} so byte n sits at bits [8n+7:8n]
   function automatic logic [7:0] req_byte(input logic [71:0] frame, input logic [3:0] idx);
      return frame[{idx, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/link_timeout.sv
// link_timeout: wait counter that flags expiry after LIMIT enabled cycles without a clear
module link_timeout
   import alu_link_defs::*;
#(
   parameter logic [19:0] LIMIT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [19:0] cnt;
   assign expired = cnt == LIMIT - 20'd1;
   always_ff @(posedge clk) begin
      if (!reset || clear) cnt <= '0;
      else if (enable && !expired) cnt <= cnt + 20'd1;
   end
endmodule

// File: rtl/alu_host_link.sv
// alu_host_link: initiator end of the ALU serial link; sends a 9-byte request, collects a 4-byte result
module alu_host_link
   import alu_link_defs::*;
#(
   parameter logic [19:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [7:0]  cmd_op,
   output logic [7:0]  d_out,
   output logic        tx_start,
   input  logic        tx_done,
   input  logic [7:0]  d_in,
   input  logic        rx_done,
   output logic [31:0] res_data,
   output logic        res_valid,
   output logic        res_timeout,
   output logic        busy
);
   logic [2:0]  state, state_nxt;
   logic [3:0]  idx;
   logic [71:0] frame;
   logic [23:0] res_buf;
   logic        accept, tx_take, rx_take, waiting, expired, tmo;

   assign accept   = state == ST_IDLE && cmd_valid && cmd_ready;
   assign tx_take  = state == ST_WAIT_TX && tx_done;
   assign rx_take  = state == ST_RECV && rx_done;
   assign waiting  = state == ST_WAIT_TX || state == ST_RECV;
   assign tmo      = waiting && state_nxt == ST_IDLE;
   assign busy     = state != ST_IDLE;
   assign tx_start = state == ST_LOAD;
   assign res_valid = state == ST_RESP;

   // A completing byte takes priority over an expiring wait
   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE:    state_nxt = accept ? ST_LOAD : ST_IDLE;
         ST_LOAD:    state_nxt = ST_WAIT_TX;
         ST_WAIT_TX: state_nxt = tx_done ? (idx == REQ_BYTES - 4'd1 ? ST_RECV : ST_LOAD)
                                         : expired ? ST_IDLE : ST_WAIT_TX;
         ST_RECV:    state_nxt = rx_done ? (idx == RES_BYTES - 4'd1 ? ST_RESP : ST_RECV)
                                         : expired ? ST_IDLE : ST_RECV;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   link_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (state_nxt != state || rx_take),
      .enable (waiting),
      .expired(expired)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         frame       <= '0;
         res_buf     <= '0;
         d_out       <= '0;
         res_data    <= '0;
         res_timeout <= 1'b0;
         cmd_ready   <= 1'b0;
      end else begin
         state       <= state_nxt;
         res_timeout <= tmo;
         cmd_ready   <= state_nxt == ST_IDLE;
         if (accept) begin
            frame <= {cmd_op, cmd_b, cmd_a};
            d_out <= cmd_a[7:0];
            idx   <= '0;
         end
         if (tx_take) begin
            idx <= state_nxt == ST_RECV ? 4'd0 : idx + 4'd1;
            if (state_nxt == ST_LOAD) d_out <= req_byte(frame, idx + 4'd1);
         end
         // Result bytes shift in LSB-first; res_data only updates on a complete frame
         if (rx_take) begin
            idx     <= idx + 4'd1;
            res_buf <= {d_in, res_buf[23:8]};
            if (state_nxt == ST_RESP) res_data <= {d_in, res_buf};
         end
      end
   end
endmodule

// File: tb/tb_alu_host_link.sv
// tb_alu_host_link: randomized self-checking bench for alu_host_link against a byte-level link model
module tb_alu_host_link;
   localparam int T = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic [7:0]  cmd_op = '0;
   logic [7:0]  d_out;
   logic        tx_start;
   logic        tx_done = 1'b0;
   logic [7:0]  d_in = '0;
   logic        rx_done = 1'b0;
   logic [31:0] res_data;
   logic        res_valid;
   logic        res_timeout;
   logic        busy;

   int total = 0, bad = 0;
   int n_tx = 0, n_rv = 0, n_rt = 0;
   logic prev_tx = 1'b0;
   logic [31:0] last_res = '0;

   always #5 clk = ~clk;

   alu_host_link #(.TIMEOUT_CYCLES(20'd50)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .d_out(d_out), .tx_start(tx_start),
      .tx_done(tx_done), .d_in(d_in), .rx_done(rx_done), .res_data(res_data),
      .res_valid(res_valid), .res_timeout(res_timeout), .busy(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Request byte n of the frame: A bytes, then B bytes, LSB first, then the opcode
   function automatic logic [7:0] exp_byte(input logic [31:0] a, input logic [31:0] b,
                                           input logic [7:0] op, input int i);
      return i < 4 ? 8'(a >> (8 * i)) : i < 8 ? 8'(b >> (8 * (i - 4))) : op;
   endfunction

   // Advance to the next falling edge and audit the link-wide invariants
   task automatic tick();
      @(negedge clk);
      if (tx_start) begin
         n_tx++;
         check("tx_back_to_back", 32'(prev_tx), 0);
      end
      if (res_valid) begin
         n_rv++;
         check("valid_with_timeout", 32'(res_timeout), 0);
      end
      if (res_timeout) n_rt++;
      if (busy) check("ready_while_busy", 32'(cmd_ready), 0);
      prev_tx = tx_start;
   endtask

   task automatic start(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
      int w = 0;
      while (!cmd_ready && w < 50) begin
         tick();
         w++;
      end
      check("ready_before_cmd", 32'(cmd_ready), 1);
      cmd_a = a;
      cmd_b = b;
      cmd_op = op;
      cmd_valid = 1'b1;
   endtask

   // Plays the transmitter/receiver side of one transaction; gaps are measured from the last handshake
   task automatic serve(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                        input int nrx, input logic [31:0] resp, input int txgap, input int rxgap,
                        input bit stray, input bit hold);
      int w, g, tx0, rv0, rt0;
      tx0 = n_tx;
      rv0 = n_rv;
      rt0 = n_rt;
      tick();
      check("accept_latency", 32'(tx_start), 1);
      if (!hold) begin
         cmd_valid = 1'b0;
         cmd_a = $urandom;
         cmd_b = $urandom;
         cmd_op = 8'($urandom);
      end
      for (int i = 0; i < 9; i++) begin
         w = 0;
         while (!tx_start && w < 3) begin
            tick();
            w++;
         end
         check("tx_start", 32'(tx_start), 1);
         check($sformatf("d_out_%0d", i), 32'(d_out), 32'(exp_byte(a, b, op, i)));
         g = txgap > 0 ? txgap : int'($urandom_range(2, T - 1));
         for (int k = 0; k < g; k++) begin
            if (stray && k == 1) begin
               rx_done = 1'b1;
               d_in = 8'hAA;
            end
            tick();
            rx_done = 1'b0;
         end
         check("d_out_hold", 32'(d_out), 32'(exp_byte(a, b, op, i)));
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         if (i < 8) check("tx_after_done", 32'(tx_start), 1);
      end
      for (int j = 0; j < nrx; j++) begin
         g = rxgap > 0 ? rxgap : int'($urandom_range(stray ? 2 : 1, T));
         for (int k = 1; k < g; k++) begin
            if (stray && k == 1) tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
         end
         d_in = 8'(resp >> (8 * j));
         rx_done = 1'b1;
         tick();
         rx_done = 1'b0;
         d_in = 8'($urandom);
      end
      if (nrx == 4) begin
         check("res_valid", 32'(res_valid), 1);
         check("res_data", res_data, resp);
         last_res = resp;
         tick();
         check("res_valid_pulse", 32'(res_valid), 0);
         check("res_data_hold", res_data, resp);
         check("ready_after_res", 32'(cmd_ready), 1);
         check("valid_count", 32'(n_rv - rv0), 1);
         check("no_timeout", 32'(n_rt - rt0), 0);
      end else begin
         w = 0;
         while (!res_timeout && w < 3 * T) begin
            tick();
            w++;
         end
         check("timeout_latency", 32'(w), 32'(T));
         check("timeout_res_data", res_data, last_res);
         tick();
         check("timeout_pulse", 32'(res_timeout), 0);
         check("ready_after_timeout", 32'(cmd_ready), 1);
         check("timeout_count", 32'(n_rt - rt0), 1);
         check("no_valid", 32'(n_rv - rv0), 0);
      end
      check("tx_count", 32'(n_tx - tx0), 9);
   endtask

   task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                      input int nrx, input logic [31:0] resp, input int txgap, input int rxgap,
                      input bit stray);
      start(a, b, op);
      serve(a, b, op, nrx, resp, txgap, rxgap, stray, 1'b0);
   endtask

   initial begin
      logic [31:0] a, b, r;
      logic [7:0] op;
      int tx0, rv0, rt0;
      repeat (3) tick();
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res_timeout", 32'(res_timeout), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_d_out", 32'(d_out), 0);
      check("rst_res_data", res_data, 0);
      reset = 1'b1;
      tick();
      check("ready_after_release", 32'(cmd_ready), 1);

      txn(32'd5, 32'd3, 8'h20, 4, 32'h00000008, 10, 0, 1'b0);
      txn(32'hDEADBEEF, 32'h01020304, 8'h5A, 4, 32'h12345678, 0, 0, 1'b0);
      txn($urandom, $urandom, 8'($urandom), 4, $urandom, 0, 0, 1'b1);
      txn($urandom, $urandom, 8'($urandom), 4, $urandom, 0, T, 1'b0);
      txn($urandom, $urandom, 8'($urandom), 2, $urandom, 0, 0, 1'b0);
      txn($urandom, $urandom, 8'($urandom), 0, $urandom, 0, 0, 1'b0);

      a = $urandom;
      b = $urandom;
      op = 8'($urandom);
      start(a, b, op);
      serve(a, b, op, 4, $urandom, 0, 0, 1'b0, 1'b1);
      serve(a, b, op, 4, $urandom, 0, 0, 1'b0, 1'b0);

      repeat (5) begin
         r = $urandom;
         txn($urandom, $urandom, 8'($urandom), ($urandom_range(0, 3) == 0) ? 3 : 4, r, 0, 0,
             1'($urandom));
      end

      // Abort in the middle of the request frame
      start(32'h11223344, 32'h55667788, 8'h99);
      tick();
      cmd_valid = 1'b0;
      repeat (3) begin
         repeat (4) tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
      end
      tick();
      reset = 1'b0;
      tx0 = n_tx;
      rv0 = n_rv;
      rt0 = n_rt;
      repeat (3) tick();
      check("mid_rst_tx_start", 32'(tx_start), 0);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 0);
      check("mid_rst_d_out", 32'(d_out), 0);
      check("mid_rst_res_data", res_data, 0);
      check("mid_rst_res_valid", 32'(res_valid), 0);
      check("mid_rst_res_timeout", 32'(res_timeout), 0);
      reset = 1'b1;
      tick();
      check("mid_rst_ready_release", 32'(cmd_ready), 1);
      repeat (10) begin
         tx_done = 1'b1;
         rx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         rx_done = 1'b0;
         tick();
      end
      check("mid_rst_no_tx", 32'(n_tx - tx0), 0);
      check("mid_rst_no_valid", 32'(n_rv - rv0), 0);
      check("mid_rst_no_timeout", 32'(n_rt - rt0), 0);
      last_res = '0;
      txn($urandom, $urandom, 8'($urandom), 4, $urandom, 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_host_link.md
ALU_HOST_LINK -- requirements
Module: alu_host_link

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 20'd1000000: clock cycles allowed per wait (tx_done or next rx byte) before abort.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-004 cmd_valid  input  1  host command present.
REQ-005 cmd_ready  output  1  block idle and able to accept a command.
REQ-006 cmd_a  input  32  operand A.
REQ-007 cmd_b  input  32  operand B.
REQ-008 cmd_op  input  8  ALU opcode.
REQ-009 d_out  output  8  byte to the byte transmitter.
REQ-010 tx_start  output  1  one-cycle pulse launching d_out.
REQ-011 tx_done  input  1  transmitter finished the current byte.
REQ-012 d_in  input  8  byte from the byte receiver.
REQ-013 rx_done  input  1  one-cycle pulse, d_in valid.
REQ-014 res_data  output  32  assembled ALU result.
REQ-015 res_valid  output  1  one-cycle pulse, res_data valid.
REQ-016 res_timeout  output  1  one-cycle pulse, transaction aborted.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The block SHALL act as the initiator end of the ALU serial link: send a 9-byte request frame, then collect a 4-byte result frame.
REQ-019 Request frame order SHALL be A[7:0], A[15:8], A[23:16], A[31:24], B[7:0] .. B[31:24], opcode; result frame SHALL be Out[7:0] first, Out[31:24] last.
REQ-020 States SHALL be IDLE, LOAD, WAIT_TX, RECV, RESP.
REQ-021 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, cmd_a/cmd_b/cmd_op SHALL be captured into internal registers and state -> LOAD; later changes on cmd_* SHALL be ignored.
REQ-022 LOAD: d_out SHALL present byte[idx], tx_start SHALL pulse for exactly one cycle, state -> WAIT_TX; tx_start SHALL occur the cycle after acceptance (latency 1).
REQ-023 WAIT_TX: on tx_done, idx increments; idx<9 -> LOAD (next tx_start exactly 1 cycle after tx_done), idx==9 -> RECV with idx cleared.
REQ-024 d_out SHALL hold its value from the tx_start cycle until the next LOAD.
REQ-025 RECV: each rx_done SHALL write d_in into res byte[idx] and increment idx; on the 4th byte state -> RESP.
REQ-026 RESP: res_valid SHALL pulse one cycle (the cycle after the 4th rx_done), res_data stable from then until the next result, state -> IDLE.
REQ-027 A wait counter SHALL clear on entry to WAIT_TX, entry to RECV and every accepted rx_done; reaching TIMEOUT_CYCLES-1 SHALL pulse res_timeout, leave res_data unchanged and return to IDLE.
REQ-028 rx_done outside RECV SHALL be ignored (stray bytes dropped); tx_done outside WAIT_TX SHALL be ignored.
REQ-029 rx_done in the same cycle the counter expires SHALL win: byte accepted, no timeout.
REQ-030 res_valid and res_timeout SHALL never be high in the same cycle; cmd_ready SHALL be low whenever busy is high.

Reset
REQ-031 While reset==0: state IDLE, idx 0, counter 0, tx_start 0, res_valid 0, res_timeout 0, busy 0, cmd_ready 0, d_out 8'h00, res_data 32'h0.
REQ-032 cmd_ready SHALL rise the first cycle after reset is released.
REQ-033 Reset mid-transaction SHALL abort without any further tx_start, res_valid or res_timeout pulse.

Structure
REQ-034 Shared header alu_link_defs SHALL hold the state encodings, REQ_BYTES=9, RES_BYTES=4 and the TIMEOUT_CYCLES default.
REQ-035 The wait counter SHALL be a sub-module link_timeout (clear, enable, expired), reusable by the responder side.

Verification
REQ-036 Reset held 3 cycles mid-frame -> all outputs at REQ-031 values, no further tx_start pulses, cmd_ready=1 one cycle after release.
REQ-037 A=5, B=3, op=8'h20, tx_done 10 cycles after each tx_start -> d_out sequence 05 00 00 00 03 00 00 00 20; respond 08 00 00 00 -> res_valid with res_data=32'h00000008.
REQ-038 A=32'hDEADBEEF, B=32'h01020304 -> tx bytes EF BE AD DE 04 03 02 01 op; response 78 56 34 12 -> res_data=32'h12345678.
REQ-039 TIMEOUT_CYCLES=50, only 2 result bytes returned -> res_timeout pulses exactly once, res_valid never, cmd_ready=1 next cycle.
REQ-040 rx_done pulsed during WAIT_TX with d_in=8'hAA -> ignored; later correct response assembled without 8'hAA.
REQ-041 cmd_valid held high through a full transaction -> second command accepted only after return to IDLE; tx_start never pulses in two consecutive cycles.
